duc_upconvert: RTL and testbench

- Transmit-side counterpart of the down-conversion/decimation path: accepts complex baseband samples at 16 kHz, interpolates by 30 with a CIC, and complex-mixes with an external LO to produce a complex modulated signal at 480 kHz.
- Runs entirely on the 480 kHz clock; the baseband rate is a strobe derived from an internal phase counter.
- Its output feeds the receive chain in loopback benches.

---
 rtl/duc_pkg.sv | 60 ++++++
 rtl/duc_upconvert_cic_interp.sv | 56 +++++
 rtl/duc_upconvert.sv | 128 ++++++++++++
 tb/tb_duc_upconvert.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/duc_pkg.sv
// duc_pkg: shared widths, width-derivation helpers, complex sample type and
// the output round/saturate helper used when DUC_ROUND_EN is defined.
package duc_pkg;

  localparam int DUC_IN_W     = 11;
  localparam int DUC_LO_W     = 11;
  localparam int DUC_RATE     = 30;
  localparam int DUC_N_STAGES = 3;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint unsigned ipow(input longint unsigned b, input int e);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < e; i++) p = p * b;
    return p;
  endfunction

  // Interpolating CIC growth is RATE**(N_STAGES-1) at the output.
  function automatic int cic_w_calc(input int in_w, input int rate, input int n_stages);
    return in_w + clog2(ipow(64'(rate), n_stages - 1));
  endfunction

  // Full-precision complex product plus one bit for the add/subtract.
  function automatic int out_w_calc(input int cic_w, input int lo_w);
    return cic_w + lo_w + 1;
  endfunction

  localparam int DUC_CIC_W = cic_w_calc(DUC_IN_W, DUC_RATE, DUC_N_STAGES);
  localparam int DUC_OUT_W = out_w_calc(DUC_CIC_W, DUC_LO_W);

  typedef struct packed {
    logic signed [DUC_OUT_W-1:0] re;
    logic signed [DUC_OUT_W-1:0] im;
  } cplx_t;

  // Rounded output keeps 12 significant bits; one guard bit of the full
  // word is never exercised by in-range products, so it is dropped too.
  localparam int RND_BITS  = 12;
  localparam int RND_GUARD = 1;
  localparam logic signed [63:0] RND_MAX = (64'sd1 <<< (RND_BITS - 1)) - 64'sd1;
  localparam logic signed [63:0] RND_MIN = -(64'sd1 <<< (RND_BITS - 1));

  // Round half-up (add half LSB, floor) then clamp to the 12-bit range.
  function automatic logic signed [RND_BITS-1:0] round_sat(input logic signed [63:0] x,
                                                           input int sh);
    logic signed [63:0] q;
    q = (x + (64'sd1 <<< (sh - 1))) >>> sh;
    if (q > RND_MAX) q = RND_MAX;
    else if (q < RND_MIN) q = RND_MIN;
    return q[RND_BITS-1:0];
  endfunction

endpackage

// File: rtl/duc_upconvert_cic_interp.sv
// cic_interp: one rail of the interpolating CIC. Combs run at the baseband
// slot rate, their result is zero-stuffed and integrated at the full rate.
module cic_interp
  import duc_pkg::*;
#(
  parameter int IN_W     = DUC_IN_W,
  parameter int N_STAGES = DUC_N_STAGES,
  parameter int CIC_W    = DUC_CIC_W
) (
  input  logic                    clk480,
  input  logic                    reset,
  input  logic                    accept,
  input  logic                    stuff,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [CIC_W-1:0] dout
);

  logic signed [CIC_W-1:0] comb_d  [N_STAGES];
  logic signed [CIC_W-1:0] comb_in [N_STAGES];
  logic signed [CIC_W-1:0] comb_out;
  logic signed [CIC_W-1:0] up_reg;
  logic signed [CIC_W-1:0] integ   [N_STAGES];

  // Comb chain: each stage subtracts its previous-slot input (wraps freely).
  always_comb begin
    comb_out = CIC_W'(din);
    for (int k = 0; k < N_STAGES; k++) begin
      comb_in[k] = comb_out;
      comb_out   = comb_out - comb_d[k];
    end
  end

  // Comb delays and up_reg advance only on the accept edge.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) comb_d[k] <= '0;
      up_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_STAGES; k++) comb_d[k] <= comb_in[k];
      up_reg <= comb_out;
    end
  end

  // Integrators every cycle; input is up_reg only in the slot's first cycle.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + (stuff ? up_reg : '0);
      for (int k = 1; k < N_STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  assign dout = integ[N_STAGES-1];

endmodule

// File: rtl/duc_upconvert.sv
// duc_upconvert: 16 kHz complex baseband -> x30 CIC interpolation -> complex
// mix with external LO at 480 kHz. Optional macro DUC_ROUND_EN rounds and
// saturates the outputs to 12 significant bits at one extra edge of latency.
module duc_upconvert
  import duc_pkg::*;
#(
  parameter int IN_W     = DUC_IN_W,
  parameter int LO_W     = DUC_LO_W,
  parameter int RATE     = DUC_RATE,
  parameter int N_STAGES = DUC_N_STAGES
) (
  input  logic                                           clk480,
  input  logic                                           reset,
  input  logic signed [IN_W-1:0]                         bb_real,
  input  logic signed [IN_W-1:0]                         bb_imag,
  input  logic                                           bb_valid,
  output logic                                           bb_ready,
  input  logic signed [LO_W-1:0]                         lo_real,
  input  logic signed [LO_W-1:0]                         lo_imag,
  output logic signed [out_w_calc(cic_w_calc(IN_W, RATE, N_STAGES), LO_W)-1:0] mod_real,
  output logic signed [out_w_calc(cic_w_calc(IN_W, RATE, N_STAGES), LO_W)-1:0] mod_imag,
  output logic                                           mod_valid,
  output logic                                           underrun
);

  localparam int CIC_W = cic_w_calc(IN_W, RATE, N_STAGES);
  localparam int OUT_W = out_w_calc(CIC_W, LO_W);
  localparam int PW    = CIC_W + LO_W;
  localparam int PH_W  = clog2(64'(RATE));
`ifdef DUC_ROUND_EN
  localparam int LAT    = 6;
  localparam int RND_SH = OUT_W - RND_BITS - RND_GUARD;
`else
  localparam int LAT    = 5;
`endif

  logic [PH_W-1:0]          phase;
  logic                     stuff;
  logic signed [IN_W-1:0]   din_re, din_im;
  logic signed [CIC_W-1:0]  cic_re, cic_im;
  logic signed [PW-1:0]     ac_p1, bd_p1, ad_p1, bc_p1;
  cplx_t                    mod_p2;
  logic [LAT:0]             vld_sr;

  assign bb_ready = (phase == PH_W'(RATE - 1));
  assign stuff    = (phase == '0);
  assign din_re   = bb_valid ? bb_real : '0;
  assign din_im   = bb_valid ? bb_imag : '0;

  // Slot phase counter; bb_ready marks the last cycle of each slot.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) phase <= '0;
    else       phase <= bb_ready ? '0 : phase + PH_W'(1);
  end

  // A missed slot latches underrun until reset.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset)                      underrun <= 1'b0;
    else if (bb_ready && !bb_valid) underrun <= 1'b1;
  end

  cic_interp #(.IN_W(IN_W), .N_STAGES(N_STAGES), .CIC_W(CIC_W)) u_cic_re (
    .clk480(clk480), .reset(reset), .accept(bb_ready), .stuff(stuff),
    .din(din_re), .dout(cic_re)
  );

  cic_interp #(.IN_W(IN_W), .N_STAGES(N_STAGES), .CIC_W(CIC_W)) u_cic_im (
    .clk480(clk480), .reset(reset), .accept(bb_ready), .stuff(stuff),
    .din(din_im), .dout(cic_im)
  );

  // p1: four partial products against the LO sampled at this edge.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) begin
      ac_p1 <= '0;
      bd_p1 <= '0;
      ad_p1 <= '0;
      bc_p1 <= '0;
    end else begin
      ac_p1 <= PW'(cic_re) * PW'(lo_real);
      bd_p1 <= PW'(cic_im) * PW'(lo_imag);
      ad_p1 <= PW'(cic_re) * PW'(lo_imag);
      bc_p1 <= PW'(cic_im) * PW'(lo_real);
    end
  end

  // p2: complex combine (ac-bd, ad+bc) at full precision.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) begin
      mod_p2 <= '0;
    end else begin
      mod_p2.re <= OUT_W'(ac_p1) - OUT_W'(bd_p1);
      mod_p2.im <= OUT_W'(ad_p1) + OUT_W'(bc_p1);
    end
  end

`ifdef DUC_ROUND_EN
  cplx_t mod_p3;

  // p3: round half-up, saturate to 12 bits, sign-extend back to OUT_W.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) begin
      mod_p3 <= '0;
    end else begin
      mod_p3.re <= OUT_W'(round_sat(64'(mod_p2.re), RND_SH));
      mod_p3.im <= OUT_W'(round_sat(64'(mod_p2.im), RND_SH));
    end
  end

  assign mod_real = mod_p3.re;
  assign mod_imag = mod_p3.im;
`else
  assign mod_real = mod_p2.re;
  assign mod_imag = mod_p2.im;
`endif

  // Accept marker walks the pipeline; output is valid one edge after it lands.
  always_ff @(posedge clk480 or posedge reset) begin
    if (reset) begin
      vld_sr    <= '0;
      mod_valid <= 1'b0;
    end else begin
      vld_sr    <= {vld_sr[LAT-1:0], bb_ready};
      mod_valid <= mod_valid | vld_sr[LAT];
    end
  end

endmodule

// File: tb/tb_duc_upconvert.sv
// tb_duc_upconvert: directed + randomized bench for duc_upconvert, checked
// against a convolution model (CIC as three cascaded 30-tap boxcars).
module tb_duc_upconvert;

  localparam int RATE = 30;
  localparam int HLEN = 3 * RATE - 2;
  localparam int MAXE = 4096;
`ifdef DUC_ROUND_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic               clk480 = 1'b0;
  logic               reset;
  logic signed [10:0] bb_real, bb_imag, lo_real, lo_imag;
  logic               bb_valid;
  logic               bb_ready, mod_valid, underrun;
  logic signed [32:0] mod_real, mod_imag;

  int     checks = 0;
  int     errors = 0;
  int     n;
  int     first_acc;
  bit     und_m;
  longint h      [HLEN];
  longint acc_re [MAXE];
  longint acc_im [MAXE];
  longint lo_re_h[MAXE];
  longint lo_im_h[MAXE];

  duc_upconvert dut (
    .clk480(clk480), .reset(reset),
    .bb_real(bb_real), .bb_imag(bb_imag), .bb_valid(bb_valid), .bb_ready(bb_ready),
    .lo_real(lo_real), .lo_imag(lo_imag),
    .mod_real(mod_real), .mod_imag(mod_imag), .mod_valid(mod_valid), .underrun(underrun)
  );

  always #5 clk480 = ~clk480;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint xf(input longint v);
`ifdef DUC_ROUND_EN
    longint q;
    q = (v + (64'sd1 <<< 19)) >>> 20;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return q;
`else
    return v;
`endif
  endfunction

  // High-rate CIC output after edge s: accepted samples convolved with h.
  function automatic longint y_of(input int s, input bit im);
    longint a;
    int     e;
    a = 0;
    if (s < 1) return 0;
    for (int k = 0; k < HLEN; k++) begin
      e = s - 3 - k;
      if (e >= 1) a += (im ? acc_im[e] : acc_re[e]) * h[k];
    end
    return a;
  endfunction

  function automatic longint full_of(input int t, input bit im);
    longint a, b, c, d;
    if (t < 2) return 0;
    a = y_of(t - 2, 1'b0);
    b = y_of(t - 2, 1'b1);
    c = lo_re_h[t-1];
    d = lo_im_h[t-1];
    return im ? (a * d + b * c) : (a * c - b * d);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < MAXE; i++) begin
      acc_re[i] = 0; acc_im[i] = 0; lo_re_h[i] = 0; lo_im_h[i] = 0;
    end
    n = 0; first_acc = 0; und_m = 1'b0;
  endtask

  // One clock: record what the DUT sees at the edge, then check at negedge.
  task automatic tick();
    @(posedge clk480);
    n++;
    lo_re_h[n] = longint'(lo_real);
    lo_im_h[n] = longint'(lo_imag);
    if (n % RATE == 0) begin
      if (first_acc == 0) first_acc = n;
      if (bb_valid) begin
        acc_re[n] = longint'(bb_real);
        acc_im[n] = longint'(bb_imag);
      end else begin
        und_m = 1'b1;
      end
    end
    @(negedge clk480);
    chk("bb_ready", 64'(bb_ready), (n % RATE == RATE - 1) ? 64'sd1 : 64'sd0);
    chk("mod_valid", 64'(mod_valid),
        (first_acc != 0 && n >= first_acc + 6 + XL) ? 64'sd1 : 64'sd0);
    chk("underrun", 64'(underrun), und_m ? 64'sd1 : 64'sd0);
    chk("mod_real", 64'(mod_real), xf(full_of(n - XL, 1'b0)));
    chk("mod_imag", 64'(mod_imag), xf(full_of(n - XL, 1'b1)));
  endtask

  initial begin
    longint h2 [2*RATE-1];
    longint imp_sum;
    int     g;

    for (int i = 0; i < 2 * RATE - 1; i++) h2[i] = 0;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    for (int i = 0; i < RATE; i++)
      for (int j = 0; j < RATE; j++) h2[i+j] += 1;
    for (int i = 0; i < 2 * RATE - 1; i++)
      for (int j = 0; j < RATE; j++) h[i+j] += h2[i];
    clear_model();

    // Reset state
    reset = 1'b1; bb_valid = 1'b0;
    bb_real = '0; bb_imag = '0; lo_real = '0; lo_imag = '0;
    @(negedge clk480);
    chk("rst_mod_real", 64'(mod_real), 64'sd0);
    chk("rst_mod_imag", 64'(mod_imag), 64'sd0);
    chk("rst_mod_valid", 64'(mod_valid), 64'sd0);
    chk("rst_bb_ready", 64'(bb_ready), 64'sd0);
    chk("rst_underrun", 64'(underrun), 64'sd0);

    // DC input (1,0) with LO (1,0)
    bb_real = 11'sd1; bb_imag = '0; lo_real = 11'sd1; lo_imag = '0; bb_valid = 1'b1;
    reset = 1'b0;
    repeat (250) tick();
    chk("dc_1_real", 64'(mod_real), xf(900));
    chk("dc_1_imag", 64'(mod_imag), xf(0));

    // Full-scale DC input
    bb_real = 11'sd1023;
    repeat (250) tick();
    chk("dc_1023_real", 64'(mod_real), xf(920700));

    // Unit impulse into I after the filter has drained
    bb_real = '0;
    repeat (150) tick();
    bb_real = 11'sd1;
    g = 0;
    do begin tick(); g++; end while (n % RATE != 0 && g < 40);
    bb_real = '0;
    repeat (4) tick();
    imp_sum = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
`ifndef DUC_ROUND_EN
      if (k < 4) chk("impulse_seq", 64'(mod_real), 64'((k + 1) * (k + 2) / 2));
`endif
      imp_sum += longint'(mod_real);
    end
`ifndef DUC_ROUND_EN
    chk("impulse_sum", imp_sum, 64'sd27000);
`endif

    // Cross terms: bb=(0,1), LO=(0,1)
    bb_imag = 11'sd1; lo_real = '0; lo_imag = 11'sd1;
    repeat (250) tick();
    chk("cross_real", 64'(mod_real), xf(-900));
    chk("cross_imag", 64'(mod_imag), xf(0));

    // Random data and LO, random valid, one forced missed slot
    for (int k = 0; k < 600; k++) begin
      lo_real = 11'($urandom_range(2047));
      lo_imag = 11'($urandom_range(2047));
      if (n % RATE == 0) begin
        bb_real = 11'($urandom_range(2047));
        bb_imag = 11'($urandom_range(2047));
      end
      bb_valid = (k >= 100 && k < 130) ? 1'b0 : ($urandom_range(7) != 0);
      tick();
    end
    chk("underrun_sticky", 64'(underrun), 64'sd1);

    // Asynchronous reset mid-slot while bb_ready is high
    bb_valid = 1'b1;
    g = 0;
    while (n % RATE != RATE - 1 && g < 40) begin tick(); g++; end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_real", 64'(mod_real), 64'sd0);
    chk("mid_rst_imag", 64'(mod_imag), 64'sd0);
    chk("mid_rst_valid", 64'(mod_valid), 64'sd0);
    chk("mid_rst_ready", 64'(bb_ready), 64'sd0);
    chk("mid_rst_underrun", 64'(underrun), 64'sd0);
    @(negedge clk480);
    @(negedge clk480);
    clear_model();
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      lo_real = 11'($urandom_range(2047));
      lo_imag = 11'($urandom_range(2047));
      if (n % RATE == 0) begin
        bb_real = 11'($urandom_range(2047));
        bb_imag = 11'($urandom_range(2047));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
